wavegen_bank_controller: RTL and testbench
==========================================

// Module: wavegen_bank_controller
// PURPOSE
//  Bus-mapped bank of CHANNELS WaveGen voices behind one register window on the synth bus.
//  All bus access is sampled in the Clock domain: BusClock is synchronised and edge-detected.
//  Adds 16-bit atomic INCR/PW writes, gate-state readback and a broadcast gate register.
//  Read drive is address-qualified, so multiple banks can share BusData.
// PARAMETERS
//  CHANNELS    4  voice count, 1..8
//  WAVE_DEPTH  8  waveform, Incr and PulseWidth width, 8..16
//  ADDR        0  base byte address of the window
// PORTS
//  Clock         in     1              system clock; every flop is on posedge Clock
//  Reset         in     1              synchronous, active-high
//  BusAddress    in     16             byte address
//  BusData       inout  8              write data in; read data out
//  BusReadWrite  in     1              1 = write, 0 = read
//  BusClock      in     1              bus strobe; asynchronous to Clock
//  Waveform      out    CHANNELS*WAVE_DEPTH  ch n on [n*WAVE_DEPTH +: WAVE_DEPTH]
//  GateState     out    CHANNELS       1 = gate open, per channel
// BEHAVIOUR
//  Register map. Channel base B = ADDR + ch*8:
//   B+0 INCR_LO (shadow)     B+1 INCR_HI (commit)     B+2 GATE
//   B+3 WAVETYPE [1:0]       B+4 PW_LO (shadow)       B+5 PW_HI (commit)
//   B+6, B+7 reserved: read 0x00, writes ignored
//  Global base G = ADDR + CHANNELS*8:
//   G+0 GATE_OPEN mask: write opens each set channel; read returns GateState
//   G+1 GATE_CLOSE mask: write closes each set channel; read returns 0x00
//  Window is ADDR .. G+1; any other address is a miss.
//  Bus strobe:
//   - BusClock passes through 2 sync flops, then an edge flop; all three reset to 1.
//   - strobe = 1-cycle pulse on a sync rising edge, 3 Clock cycles after the BusClock rise.
//   - BusClock already high when Reset deasserts gives no strobe.
//   - BusAddress, BusData and BusReadWrite are sampled on the strobe cycle.
//   - The master holds them stable from before the BusClock rise until >=4 Clock cycles after it.
//  Writes (strobe, BusReadWrite=1, hit):
//   - *_LO writes the shadow byte only.
//   - *_HI commits {BusData, shadow}[WAVE_DEPTH-1:0] to the live register in one cycle.
//     WaveGen never sees a half-updated value.
//   - GATE write data!=0: GateOpen[ch] pulses 1 cycle; GateState[ch] <= 1.
//   - GATE write data==0: GateClose[ch] pulses 1 cycle; GateState[ch] <= 0.
//   - Mask writes pulse every selected channel in the same cycle. Bits >= CHANNELS are ignored.
//   - Gate pulses are asserted the cycle after the strobe and cleared the next cycle.
//   - A write of GATE=1 to an already-open channel still pulses GateOpen (retrigger).
//  Reads (strobe, BusReadWrite=0):
//   - rdata <= addressed byte on the strobe cycle.
//   - INCR_LO/PW_LO return live bits [7:0], not the shadow.
//   - INCR_HI/PW_HI return live bits, zero-padded to 8.
//   - GATE returns {7'b0, GateState[ch]}; WAVETYPE returns {6'b0, wavetype}.
//   - A read miss leaves rdata unchanged.
//  BusData drive: rdata when (BusReadWrite==0 && BusAddress in window), combinationally; else Z.
//  Reset (synchronous, highest priority):
//   - Clears incr, pw, wavetype, shadows, GateState, gate pulses and rdata.
//   - Strobes and gate pulses in flight are dropped.
//   - Waveform takes the WaveGen reset value.
//  Per-channel WaveGen instance: Clock, Reset, GateOpen/GateClose[ch], Incr, WaveType, PulseWidth.
//  An un-paired *_HI write commits with the current shadow, which is 0 after reset.
// TESTING
//  1. Reset: Reset=1 for 2 cycles.
//     -> all register reads 0x00, GateState=0, BusData=Z during writes.
//  2. Atomic incr: W(B0+0)=0x34, read B0+0 -> 0x00 (live).
//     Then W(B0+1)=0x12 -> ch0 Incr=0x1234 (WAVE_DEPTH=16), changing in a single cycle.
//  3. Gate: W(B1+2)=1 -> GateOpen[1] high exactly 1 cycle, GateState=0b0010.
//     W(B1+2)=0 -> GateClose[1] one cycle, GateState=0.
//  4. Broadcast: W(G+0)=0xFF with CHANNELS=4 -> 4 simultaneous GateOpen pulses, read G+0=0x0F.
//     Then W(G+1)=0x05 -> GateState=0b1010.
//  5. Decode: two banks at ADDR=0 and ADDR=0x40 share BusData.
//     -> read 0x43 (WAVETYPE=2) returns 0x02 with no contention.
//     -> read of 0x06 returns 0x00; write to 0x100 changes nothing.
//  6. Reset mid-op: assert Reset between the BusClock rise and the strobe.
//     -> no write, no gate pulse.
//     -> BusClock held high across reset release gives no strobe.

Source files
------------

// File: rtl/wavegen_bank_controller.sv
// Bus-mapped bank of WaveGen voices: byte-wide register window with atomic 16-bit
// Incr/PulseWidth commits, per-channel and broadcast gate control, address-qualified readback.

module wavegen #(
  parameter int WAVE_DEPTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  GateOpen,
  input  logic                  GateClose,
  input  logic [WAVE_DEPTH-1:0] Incr,
  input  logic [1:0]            WaveType,
  input  logic [WAVE_DEPTH-1:0] PulseWidth,
  output logic [WAVE_DEPTH-1:0] Waveform
);
  typedef enum logic [1:0] {WT_SAW, WT_TRIANGLE, WT_PULSE, WT_NOISE} wave_type_t;

  logic [WAVE_DEPTH-1:0] phase;
  logic [WAVE_DEPTH-1:0] next_phase;
  logic                  carry;
  logic                  gate;
  logic [15:0]           lfsr;
  logic [WAVE_DEPTH-1:0] shape;

  assign {carry, next_phase} = {1'b0, phase} + {1'b0, Incr};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shape = phase;
    case (wave_type_t'(WaveType))
      WT_SAW:      shape = phase;
      WT_TRIANGLE: shape = phase[WAVE_DEPTH-1] ? ~{phase[WAVE_DEPTH-2:0], 1'b0}
                                               :  {phase[WAVE_DEPTH-2:0], 1'b0};
      WT_PULSE:    shape = (phase < PulseWidth) ? '1 : '0;
      WT_NOISE:    shape = lfsr[WAVE_DEPTH-1:0];
      default:     shape = phase;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase    <= '0;
      gate     <= 1'b0;
      lfsr     <= 16'hACE1;
      Waveform <= '0;
    end else begin
      if (GateOpen) begin
        // An open always restarts the phase, so a retrigger is audible.
        gate  <= 1'b1;
        phase <= '0;
      end else begin
        if (GateClose) gate <= 1'b0;
        if (gate) phase <= next_phase;
      end
      if (gate && carry) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      Waveform <= gate ? shape : '0;
    end
  end
endmodule

module wavegen_bank_controller #(
  parameter int          CHANNELS   = 4,
  parameter int          WAVE_DEPTH = 8,
  parameter logic [15:0] ADDR       = 16'h0000
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [15:0]                    BusAddress,
  inout  wire  [7:0]                     BusData,
  input  logic                           BusReadWrite,
  input  logic                           BusClock,
  output logic [CHANNELS*WAVE_DEPTH-1:0] Waveform,
  output logic [CHANNELS-1:0]            GateState
);
  localparam int LAST_OFFSET = CHANNELS * 8 + 1;

  logic [2:0]            sync;          // {edge, sync2, sync1}
  logic                  strobe;
  logic [16:0]           diff;
  logic [15:0]           offset;
  logic [12:0]           sel_ch;
  logic [2:0]            reg_sel;
  logic                  hit;
  logic                  is_global;
  logic                  bus_drive;
  logic [CHANNELS-1:0]   mask;
  logic [7:0]            rdata;
  logic [7:0]            read_byte;
  logic [15:0]           live16;
  logic [CHANNELS-1:0]   gate_open;
  logic [CHANNELS-1:0]   gate_close;
  logic [WAVE_DEPTH-1:0] incr        [CHANNELS];
  logic [WAVE_DEPTH-1:0] pw          [CHANNELS];
  logic [1:0]            wavetype    [CHANNELS];
  logic [7:0]            incr_shadow [CHANNELS];
  logic [7:0]            pw_shadow   [CHANNELS];

  assign strobe    = sync[1] & ~sync[2];
  assign diff      = {1'b0, BusAddress} - {1'b0, ADDR};
  assign offset    = diff[15:0];
  assign sel_ch    = offset[15:3];
  assign reg_sel   = offset[2:0];
  assign hit       = !diff[16] && (offset <= 16'(LAST_OFFSET));
  assign is_global = (sel_ch == 13'(CHANNELS));
  assign mask      = BusData[CHANNELS-1:0];
  assign bus_drive = !BusReadWrite && hit;
  assign BusData   = bus_drive ? rdata : 8'hzz;

  always_comb begin
    read_byte = '0;
    live16    = '0;
    if (is_global) begin
      if (reg_sel == 3'd0) read_byte = 8'(GateState);
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sel_ch == 13'(c)) begin
          case (reg_sel)
            3'd0, 3'd1: live16 = 16'(incr[c]);
            3'd4, 3'd5: live16 = 16'(pw[c]);
            default:    live16 = '0;
          endcase
          case (reg_sel)
            3'd0, 3'd4: read_byte = live16[7:0];
            3'd1, 3'd5: read_byte = live16[15:8];
            3'd2:       read_byte = {7'b0, GateState[c]};
            3'd3:       read_byte = {6'b0, wavetype[c]};
            default:    read_byte = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // Forcing the sync chain high means a BusClock already high at release is not an edge.
      sync       <= '1;
      gate_open  <= '0;
      gate_close <= '0;
      GateState  <= '0;
      rdata      <= '0;
      // NOTE: these arrays are small flop banks, not RAM, so they take reset like any flop.
      for (int c = 0; c < CHANNELS; c++) begin
        incr[c]        <= '0;
        pw[c]          <= '0;
        wavetype[c]    <= '0;
        incr_shadow[c] <= '0;
        pw_shadow[c]   <= '0;
      end
    end else begin
      sync       <= {sync[1:0], BusClock};
      gate_open  <= '0;
      gate_close <= '0;
      if (strobe && hit) begin
        if (!BusReadWrite) begin
          rdata <= read_byte;
        end else if (is_global) begin
          if (reg_sel == 3'd0) begin
            gate_open <= mask;
            GateState <= GateState | mask;
          end else begin
            gate_close <= mask;
            GateState  <= GateState & ~mask;
          end
        end else begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (sel_ch == 13'(c)) begin
              case (reg_sel)
                3'd0: incr_shadow[c] <= BusData;
                3'd1: incr[c]        <= WAVE_DEPTH'({BusData, incr_shadow[c]});
                3'd2: begin
                  if (BusData != 8'h00) begin
                    gate_open[c] <= 1'b1;
                    GateState[c] <= 1'b1;
                  end else begin
                    gate_close[c] <= 1'b1;
                    GateState[c]  <= 1'b0;
                  end
                end
                3'd3: wavetype[c]  <= BusData[1:0];
                3'd4: pw_shadow[c] <= BusData;
                3'd5: pw[c]        <= WAVE_DEPTH'({BusData, pw_shadow[c]});
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    wavegen #(.WAVE_DEPTH(WAVE_DEPTH)) u_wavegen (
      .Clock      (Clock),
      .Reset      (Reset),
      .GateOpen   (gate_open[g]),
      .GateClose  (gate_close[g]),
      .Incr       (incr[g]),
      .WaveType   (wavetype[g]),
      .PulseWidth (pw[g]),
      .Waveform   (Waveform[g*WAVE_DEPTH +: WAVE_DEPTH])
    );
  end
endmodule

// File: tb/tb_wavegen_bank_controller.sv
// Two banks (ADDR 0x0000 and 0x0040) sharing one bus; a scoreboard monitor checks every
// strobed access for read data, bus drivers and the combined gate state.

module tb_wavegen_bank_controller;
  localparam int CH = 4;
  localparam int WD = 16;

  typedef struct {
    string      name;
    logic       is_read;
    logic [7:0] data;
    int         drivers;
    logic [7:0] gates;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, bus_clk = 1'b0, bus_rw = 1'b0, tb_en = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [7:0]  tb_data = '0;
  wire  [7:0]  bus_data;
  logic [CH*WD-1:0] wave0, wave1;
  logic [CH-1:0]    gs0, gs1;

  exp_t       sb[$];
  int         n_vec = 0, n_bad = 0;
  logic [7:0] gates_exp = '0;

  int open_cyc[CH] = '{default: 0};
  int close_cyc[CH] = '{default: 0};
  int base_open[CH], base_close[CH];
  int all_open_cyc = 0, strobe_cnt = 0, incr_changes = 0;
  logic [WD-1:0] prev_incr = '0;

  assign bus_data = tb_en ? tb_data : 8'hzz;
  always #5 clk = ~clk;

  wavegen_bank_controller #(.CHANNELS(CH), .WAVE_DEPTH(WD), .ADDR(16'h0000)) dut0 (
    .Clock(clk), .Reset(rst), .BusAddress(bus_addr), .BusData(bus_data),
    .BusReadWrite(bus_rw), .BusClock(bus_clk), .Waveform(wave0), .GateState(gs0));

  wavegen_bank_controller #(.CHANNELS(CH), .WAVE_DEPTH(WD), .ADDR(16'h0040)) dut1 (
    .Clock(clk), .Reset(rst), .BusAddress(bus_addr), .BusData(bus_data),
    .BusReadWrite(bus_rw), .BusClock(bus_clk), .Waveform(wave1), .GateState(gs1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      open_cyc[c]  += int'(dut0.gate_open[c]);
      close_cyc[c] += int'(dut0.gate_close[c]);
    end
    if (dut0.gate_open == 4'hF) all_open_cyc++;
    if (dut0.strobe) strobe_cnt++;
    if (dut0.incr[0] != prev_incr) incr_changes++;
    prev_incr = dut0.incr[0];
  end

  // Scoreboard monitor: one expected record per strobe, checked the cycle after it.
  initial begin
    exp_t e;
    int   drv;
    forever begin
      @(negedge clk);
      if (dut0.strobe === 1'b1) begin
        @(negedge clk);
        drv = int'(dut0.bus_drive) + int'(dut1.bus_drive);
        if (sb.size() == 0) begin
          check("unexpected_strobe", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check({e.name, "_drivers"}, drv, e.drivers);
          if (e.is_read && e.drivers == 1) check({e.name, "_data"}, bus_data, e.data);
          check({e.name, "_gates"}, {gs1, gs0}, e.gates);
        end
      end
    end
  end

  task automatic xfer(input logic rw, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_rw = rw; tb_en = rw; tb_data = d;
    @(negedge clk);
    bus_clk = 1'b1;
    repeat (5) @(negedge clk);
    bus_clk = 1'b0;
    repeat (3) @(negedge clk);
    tb_en = 1'b0; bus_rw = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input string name);
    sb.push_back('{name, 1'b0, d, 0, gates_exp});
    xfer(1'b1, a, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    sb.push_back('{name, 1'b1, exp, 1, gates_exp});
    xfer(1'b0, a, 8'h00);
  endtask

  task automatic rd_miss(input logic [15:0] a, input string name);
    sb.push_back('{name, 1'b1, 8'h00, 0, gates_exp});
    xfer(1'b0, a, 8'h00);
  endtask

  task automatic snap();
    base_open  = open_cyc;
    base_close = close_cyc;
  endtask

  // Packs per-channel pulse-cycle counts into nibbles: opens in [15:0], closes in [31:16].
  task automatic pulses(input string name, input logic [3:0] exp_open, input logic [3:0] exp_close);
    logic [31:0] act, exp;
    act = '0; exp = '0;
    for (int c = 0; c < CH; c++) begin
      act[4*c +: 4]      = 4'(open_cyc[c] - base_open[c]);
      act[16+4*c +: 4]   = 4'(close_cyc[c] - base_close[c]);
      exp[4*c +: 4]      = {3'b0, exp_open[c]};
      exp[16+4*c +: 4]   = {3'b0, exp_close[c]};
    end
    check(name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, a0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_wave0", wave0, 0);
    check("rst_gates", {gs1, gs0}, 0);
    rd(16'h0000, 8'h00, "rst_incr_lo");
    rd(16'h0001, 8'h00, "rst_incr_hi");
    rd(16'h0003, 8'h00, "rst_wavetype");
    rd(16'h0005, 8'h00, "rst_pw_hi");
    rd(16'h0020, 8'h00, "rst_gopen_rd");

    // Atomic Incr: shadow write is invisible, commit lands in one step.
    c0 = incr_changes;
    wr(16'h0000, 8'h34, "w_incr_lo");
    rd(16'h0000, 8'h00, "incr_lo_live");
    rd(16'h0001, 8'h00, "incr_hi_live");
    wr(16'h0001, 8'h12, "w_incr_hi");
    check("incr_commit", dut0.incr[0], 32'h1234);
    check("incr_single_step", incr_changes - c0, 1);
    rd(16'h0000, 8'h34, "incr_lo_rd");
    rd(16'h0001, 8'h12, "incr_hi_rd");
    wr(16'h0004, 8'h78, "w_pw_lo");
    wr(16'h0005, 8'h56, "w_pw_hi");
    rd(16'h0004, 8'h78, "pw_lo_rd");
    rd(16'h0005, 8'h56, "pw_hi_rd");
    wr(16'h0009, 8'hAB, "w_unpaired_hi");
    rd(16'h0008, 8'h00, "unpaired_lo_rd");
    rd(16'h0009, 8'hAB, "unpaired_hi_rd");

    // Per-channel gate, including retrigger of an already-open channel.
    gates_exp = 8'h02; snap();
    wr(16'h000A, 8'h01, "w_gate1_open");
    pulses("gate1_open_pulse", 4'b0010, 4'b0000);
    rd(16'h000A, 8'h01, "gate1_rd");
    rd(16'h0002, 8'h00, "gate0_rd");
    gates_exp = 8'h00; snap();
    wr(16'h000A, 8'h00, "w_gate1_close");
    pulses("gate1_close_pulse", 4'b0000, 4'b0010);
    gates_exp = 8'h02;
    wr(16'h000A, 8'h80, "w_gate1_open_b");
    snap();
    wr(16'h000A, 8'h01, "w_gate1_retrig");
    pulses("gate1_retrig_pulse", 4'b0010, 4'b0000);

    // Broadcast masks.
    gates_exp = 8'h0F; snap(); a0 = all_open_cyc;
    wr(16'h0020, 8'hFF, "w_bcast_open");
    pulses("bcast_open_pulse", 4'b1111, 4'b0000);
    check("bcast_simultaneous", all_open_cyc - a0, 1);
    rd(16'h0020, 8'h0F, "gopen_rd");
    rd(16'h0021, 8'h00, "gclose_rd");
    gates_exp = 8'h0A; snap();
    wr(16'h0021, 8'h05, "w_bcast_close");
    pulses("bcast_close_pulse", 4'b0000, 4'b0101);
    rd(16'h0020, 8'h0A, "gopen_rd2");
    rd(16'h0012, 8'h00, "gate2_rd");
    rd(16'h001A, 8'h01, "gate3_rd");

    // Decode across two banks on a shared bus.
    wr(16'h0043, 8'h02, "w_b1_wavetype");
    rd(16'h0043, 8'h02, "b1_wavetype_rd");
    rd(16'h0006, 8'h00, "reserved_rd");
    wr(16'h0006, 8'hFF, "w_reserved");
    rd(16'h0006, 8'h00, "reserved_rd2");
    wr(16'h0100, 8'hFF, "w_miss");
    rd(16'h0003, 8'h00, "b0_wavetype_rd");
    rd(16'h0060, 8'h00, "b1_gopen_rd");
    rd(16'h0000, 8'h34, "incr_lo_rd2");
    rd_miss(16'h0022, "miss_rd");
    check("miss_keeps_rdata", dut0.rdata, 8'h34);

    // Reset between the BusClock rise and the strobe drops the access.
    s0 = strobe_cnt; snap();
    @(negedge clk);
    bus_addr = 16'h000A; bus_rw = 1'b1; tb_en = 1'b1; tb_data = 8'h01;
    @(negedge clk); bus_clk = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midop_no_strobe", strobe_cnt - s0, 0);
    pulses("midop_no_pulse", 4'b0000, 4'b0000);
    check("midop_gates", {gs1, gs0}, 0);
    // BusClock held high across a second reset release.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check("high_release_no_strobe", strobe_cnt - s0, 0);
    bus_clk = 1'b0; tb_en = 1'b0; bus_rw = 1'b0;
    repeat (3) @(negedge clk);
    gates_exp = 8'h02; snap();
    wr(16'h000A, 8'h01, "w_after_reset");
    pulses("after_reset_pulse", 4'b0010, 4'b0000);
    rd(16'h0000, 8'h00, "incr_cleared_rd");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
